// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
package counter_pkg;

   typedef enum logic {ST_RUN, ST_HALT} udc_state_t;

   function automatic int unsigned udc_terminal(input logic up,
                                                input int unsigned modulus);
      return up ? modulus - 1 : 0;
   endfunction

endpackage

// File: rtl/updown_mod_counter_prescaler.sv
// udc_prescaler: divides enabled cycles down to one tick per PRESCALE.
// Instantiated by updown_mod_counter only when UDC_PRESCALE_EN is defined.
module udc_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic zero,
   output logic tick
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (zero) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with load, clear, wrap pulse and one-shot halt.
// Define UDC_PRESCALE_EN to step only once every PRESCALE enabled cycles.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MOD      = 16,
   parameter int PRESCALE = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         up_down,
   input  logic         one_shot,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] Q,
   output logic         tc,
   output logic         wrap,
   output logic         done
);

   localparam logic [N-1:0] MAXV = N'(MOD - 1);
   localparam logic [N:0]   MODW = (N + 1)'(MOD);

   if (MOD < 2 || MOD > 2 ** N) begin : g_bad_mod
      $error("MOD must be within 2..2**N");
   end
   if (PRESCALE < 1) begin : g_bad_pre
      $error("PRESCALE must be >= 1");
   end

   udc_state_t   state;
   logic [N-1:0] term;
   logic [N-1:0] load_clamp;
   logic         run;
   logic         tick;
   logic         at_term;
   logic         step;

   assign run = enable & (state == ST_RUN);

`ifdef UDC_PRESCALE_EN
   udc_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset_n(reset_n),
      .run    (run),
      .zero   (clear | load),
      .tick   (tick)
   );
`else
   assign tick = 1'b1;
`endif

   assign term       = N'(udc_terminal(up_down, MOD));
   assign at_term    = (Q == term);
   assign tc         = run & tick & at_term;
   assign step       = run & tick & ~clear & ~load;
   assign load_clamp = ({1'b0, load_val} >= MODW) ? MAXV : load_val;
   assign done       = (state == ST_HALT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Q     <= '0;
         wrap  <= 1'b0;
         state <= ST_RUN;
      end else if (clear) begin
         Q     <= '0;
         wrap  <= 1'b0;
         state <= ST_RUN;
      end else if (load) begin
         Q     <= load_clamp;
         wrap  <= 1'b0;
         state <= ST_RUN;
      end else begin
         wrap <= 1'b0;
         if (step) begin
            if (at_term) begin
               // one-shot freezes on the terminal value instead of wrapping
               if (one_shot) begin
                  state <= ST_HALT;
               end else begin
                  Q    <= up_down ? '0 : MAXV;
                  wrap <= 1'b1;
               end
            end else begin
               Q <= up_down ? Q + N'(1) : Q - N'(1);
            end
         end
      end
   end

endmodule
